bpsk_correlator_demod: RTL and testbench
========================================

Name: bpsk_correlator_demod

Overview:
- Parametrised integrate-and-dump BPSK demodulator. It sits between the sample source and the bit sink, replacing the fixed single-purpose demodulator.
- Each received sample is multiplied by a reference sine amplitude. Products are summed over SAMPLES_PER_SYMBOL samples, and a hard bit, a soft metric and a confidence flag are produced once per symbol.
- Adds sample-valid gating, resynchronisation, accumulator saturation, optional differential decoding and a symbol counter.

Parameters:
- DATA_WIDTH, 16: signed width of the input sample and of the reference amplitude.
- SAMPLES_PER_SYMBOL, 32: samples integrated per symbol; must be ≥ 2.
- ACC_WIDTH, 48: signed accumulator width.
- SOFT_WIDTH, 16: signed soft-metric output width.
- SOFT_SHIFT, 8: arithmetic right shift applied to the final sum before soft saturation.
- DIFFERENTIAL, 0: 1 = output bit is the decision XOR the previous decision.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- sample_valid  in  1  signal is a valid sample this cycle.
- signal  in  DATA_WIDTH  signed received sample.
- ref_phase  out  16  phase index into the external sine table (0..SAMPLES_PER_SYMBOL-1).
- ref_amp  in  DATA_WIDTH  signed table amplitude for ref_phase; combinational, same cycle.
- resync  in  1  restart symbol at the current sample.
- threshold  in  ACC_WIDTH-1  unsigned magnitude below which a decision is low-confidence.
- sym_valid  out  1  one-cycle pulse: symbol outputs updated.
- sym_bit  out  1  decided bit.
- sym_soft  out  SOFT_WIDTH  signed soft metric.
- low_conf  out  1  |final sum| < threshold.
- saturated  out  1  accumulator clipped during this symbol.
- symbol_count  out  16  symbols emitted; wraps at 65535→0.

Behaviour:
- Reset (reset_n low at edge):
  - phase, accumulator, sat_pending and previous-decision register go to 0.
  - All outputs go to 0, including ref_phase.
  - Reset overrides all inputs; a partial symbol is discarded.
- ref_phase is the registered phase counter.
- Product: signal*ref_amp, full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
- Accumulate on sample_valid=1 only: next_sum = acc + product, saturating at the ACC_WIDTH signed max/min.
  - Any clip sets sat_pending.
- sample_valid=0: phase, accumulator and outputs hold; sym_valid=0.
- Non-final valid sample (phase < SAMPLES_PER_SYMBOL-1): acc <= next_sum, phase <= phase+1.
- Final valid sample (phase == SAMPLES_PER_SYMBOL-1): final = next_sum. On the same edge:
  - decision = (final < 0). final ≥ 0 gives 0; exactly 0 gives 0.
  - sym_bit = DIFFERENTIAL ? decision XOR prev_decision : decision.
  - prev_decision <= decision.
  - sym_soft = final >>> SOFT_SHIFT (floor), saturated to the SOFT_WIDTH range.
  - low_conf = |final| < threshold, compared unsigned at ACC_WIDTH. |min| is treated as max magnitude.
  - saturated = sat_pending OR clip on this sample.
  - sym_valid <= 1 for exactly one cycle; symbol_count <= symbol_count+1.
  - acc <= 0, phase <= 0, sat_pending <= 0.
- Latency: outputs and sym_valid become visible in the cycle after the final sample's edge. Outputs hold until the next symbol.
- resync=1 with sample_valid=1: the sample is taken as phase 0 of a new symbol.
  - acc <= product, phase <= 1, sat_pending <= 0.
  - No symbol is emitted; ref_amp used is the amplitude for phase 0. The bench drives ref_amp for the current ref_phase; resync forces the lookup index to 0 combinationally.
- resync=1 with sample_valid=0: acc <= 0, phase <= 0, sat_pending <= 0; no emission.
- resync on a final-phase sample: resync wins; no emission.
- prev_decision is not cleared by resync; only reset clears it.
- symbol_count wraps 65535→0 without a flag.

Test Plan:
- Bench table for SPS=4, SOFT_SHIFT=8, threshold=1000: amps {0,1000,0,-1000}.
  - Stimulus: samples {0,100,0,-100}, all valid.
  - Required: sym_valid once, 1 cycle after the 4th sample; sym_bit=0, sym_soft=781, low_conf=0, symbol_count=1.
- Negated samples {0,-100,0,100}: sym_bit=1, sym_soft=-782.
- Samples all 0: final=0 → sym_bit=0, sym_soft=0, low_conf=1.
- Valid gaps: same samples as the first scenario with sample_valid low for 3 cycles between each.
  - Required: identical results; sym_valid only after the 4th valid sample.
- DIFFERENTIAL=1, symbols decided 0,1,1,0 → sym_bit sequence 0,1,0,1.
- Resync after 2 samples, then 4 full samples: exactly one emission, computed only from the post-resync samples.
- ACC_WIDTH=20, full-scale samples: saturated=1 on that symbol, cleared on the next clean symbol.
- reset_n low mid-symbol: all outputs go to 0; the next emission needs 4 fresh samples.

Source files
------------

// File: rtl/bpsk_correlator_demod.sv
// ----------------------------------------------------------------------------
// bpsk_correlator_demod
//
// Integrate-and-dump BPSK demodulator. Each valid sample is multiplied by the
// reference sine amplitude for the current phase. The products are summed
// over SAMPLES_PER_SYMBOL samples. Once per symbol the block emits a hard
// bit, a soft metric, a low-confidence flag and a saturation flag.
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   synchronous active-low reset
//   sample_valid  in   signal carries a valid sample this cycle
//   signal        in   signed received sample
//   ref_phase     out  index into the external sine table
//   ref_amp       in   signed table amplitude for ref_phase (same cycle)
//   resync        in   start a new symbol at the current sample
//   threshold     in   magnitude below which a decision is low-confidence
//   sym_valid     out  one-cycle pulse, symbol outputs updated
//   sym_bit       out  decided bit (optionally differentially decoded)
//   sym_soft      out  signed soft metric
//   low_conf      out  |final sum| < threshold
//   saturated     out  accumulator clipped during this symbol
//   symbol_count  out  symbols emitted, wraps silently
// ----------------------------------------------------------------------------
module bpsk_correlator_demod #(
   parameter int DATA_WIDTH         = 16,
   parameter int SAMPLES_PER_SYMBOL = 32,
   parameter int ACC_WIDTH          = 48,
   parameter int SOFT_WIDTH         = 16,
   parameter int SOFT_SHIFT         = 8,
   parameter bit DIFFERENTIAL       = 1'b0
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] signal,
   output logic        [15:0]           ref_phase,
   input  logic signed [DATA_WIDTH-1:0] ref_amp,
   input  logic                         resync,
   input  logic        [ACC_WIDTH-2:0]  threshold,
   output logic                         sym_valid,
   output logic                         sym_bit,
   output logic signed [SOFT_WIDTH-1:0] sym_soft,
   output logic                         low_conf,
   output logic                         saturated,
   output logic        [15:0]           symbol_count
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   // Working width for the raw sum: wide enough that acc + product never wraps.
   localparam int SUM_WIDTH  = ((ACC_WIDTH > PROD_WIDTH) ? ACC_WIDTH : PROD_WIDTH) + 2;

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0] SOFT_MAX =
      {{(ACC_WIDTH-SOFT_WIDTH+1){1'b0}}, {(SOFT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SOFT_MIN =
      {{(ACC_WIDTH-SOFT_WIDTH+1){1'b1}}, {(SOFT_WIDTH-1){1'b0}}};
   localparam logic [15:0] LAST_PHASE = 16'(SAMPLES_PER_SYMBOL - 1);

   logic        [15:0]           phase;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic                         sat_pending;
   logic                         prev_decision;

   logic signed [PROD_WIDTH-1:0] product;
   logic signed [SUM_WIDTH-1:0]  raw_sum;
   logic signed [ACC_WIDTH-1:0]  next_sum;
   logic                         clip;
   logic signed [ACC_WIDTH-1:0]  shifted;
   logic signed [ACC_WIDTH-1:0]  soft_clamped;
   logic        [ACC_WIDTH-1:0]  magnitude;
   logic                         decision;
   logic                         final_sample;

   // resync restarts the symbol on this very sample, so the table lookup must
   // already point at phase 0 in the same cycle.
   assign ref_phase = resync ? 16'd0 : phase;

   assign product      = signal * ref_amp;
   assign final_sample = sample_valid && !resync && (phase == LAST_PHASE);

   // NOTE: every signal assigned in always_comb gets a default at the top of
   // the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      raw_sum      = '0;
      next_sum     = '0;
      clip         = 1'b0;
      shifted      = '0;
      soft_clamped = '0;
      magnitude    = '0;
      decision     = 1'b0;

      // A resync sample starts from an empty accumulator.
      raw_sum = (resync ? SUM_WIDTH'(0) : SUM_WIDTH'(acc)) + SUM_WIDTH'(product);

      if (raw_sum > SUM_WIDTH'(ACC_MAX)) begin
         next_sum = ACC_MAX;
         clip     = 1'b1;
      end else if (raw_sum < SUM_WIDTH'(ACC_MIN)) begin
         next_sum = ACC_MIN;
         clip     = 1'b1;
      end else begin
         next_sum = ACC_WIDTH'(raw_sum);
      end

      decision = next_sum[ACC_WIDTH-1];

      shifted = next_sum >>> SOFT_SHIFT;
      if (shifted > SOFT_MAX)      soft_clamped = SOFT_MAX;
      else if (shifted < SOFT_MIN) soft_clamped = SOFT_MIN;
      else                         soft_clamped = shifted;

      // The most negative sum has no positive twin; report it as full scale.
      if (next_sum == ACC_MIN)      magnitude = ACC_MAX;
      else if (next_sum < 0)        magnitude = -next_sum;
      else                          magnitude = next_sum;
   end

   // NOTE: all state here uses non-blocking assignments, and the reset is
   // sampled on the clock edge, so it takes effect on the edge like any input.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         phase         <= '0;
         acc           <= '0;
         sat_pending   <= 1'b0;
         prev_decision <= 1'b0;
         sym_valid     <= 1'b0;
         sym_bit       <= 1'b0;
         sym_soft      <= '0;
         low_conf      <= 1'b0;
         saturated     <= 1'b0;
         symbol_count  <= '0;
      end else begin
         sym_valid <= 1'b0;
         if (sample_valid) begin
            if (resync) begin
               acc         <= next_sum;
               phase       <= 16'd1;
               sat_pending <= 1'b0;
            end else if (final_sample) begin
               sym_valid     <= 1'b1;
               sym_bit       <= DIFFERENTIAL ? (decision ^ prev_decision) : decision;
               prev_decision <= decision;
               sym_soft      <= SOFT_WIDTH'(soft_clamped);
               low_conf      <= (magnitude < {1'b0, threshold});
               saturated     <= sat_pending | clip;
               symbol_count  <= symbol_count + 16'd1;
               acc           <= '0;
               phase         <= '0;
               sat_pending   <= 1'b0;
            end else begin
               acc         <= next_sum;
               phase       <= phase + 16'd1;
               sat_pending <= sat_pending | clip;
            end
         end else if (resync) begin
            acc         <= '0;
            phase       <= '0;
            sat_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bpsk_correlator_demod.sv
// ----------------------------------------------------------------------------
// tb_bpsk_correlator_demod
//
// Two instances share one stimulus stream:
//   index 0: 48-bit accumulator, plain decoding
//   index 1: 20-bit accumulator, differential decoding (saturates on loud input)
// A behavioural model computes each symbol from the list of products; a
// compare process checks every output of both instances on every falling
// edge, and directed literal checks pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_bpsk_correlator_demod;

   localparam int SPS = 4;

   logic                clock;
   logic                reset_n;
   logic                sample_valid;
   logic signed [15:0]  signal;
   logic                resync;
   logic        [46:0]  thr_a;
   logic        [18:0]  thr_b;

   logic                o_sv  [2];
   logic                o_sb  [2];
   logic signed [15:0]  o_ss  [2];
   logic                o_lc  [2];
   logic                o_sat [2];
   logic        [15:0]  o_cnt [2];
   logic        [15:0]  o_ph  [2];
   logic signed [15:0]  amp   [2];

   logic signed [15:0]  amps [SPS] = '{16'sd0, 16'sd1000, 16'sd0, -16'sd1000};

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   // Model state and expected outputs.
   int     acc_w [2] = '{48, 20};
   bit     diff  [2] = '{1'b0, 1'b1};
   longint m_acc   [2];
   int     m_phase [2];
   bit     m_sat   [2];
   bit     m_prev  [2];
   bit     e_sv  [2];
   bit     e_sb  [2];
   longint e_ss  [2];
   bit     e_lc  [2];
   bit     e_sat [2];
   int     e_cnt [2];

   function automatic logic signed [15:0] lut(input logic [15:0] p);
      return (p < 16'(SPS)) ? amps[p[1:0]] : 16'sd0;
   endfunction

   assign amp[0] = lut(o_ph[0]);
   assign amp[1] = lut(o_ph[1]);

   bpsk_correlator_demod #(
      .DATA_WIDTH(16), .SAMPLES_PER_SYMBOL(SPS), .ACC_WIDTH(48),
      .SOFT_WIDTH(16), .SOFT_SHIFT(8), .DIFFERENTIAL(1'b0)
   ) u_a (
      .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid),
      .signal(signal), .ref_phase(o_ph[0]), .ref_amp(amp[0]),
      .resync(resync), .threshold(thr_a), .sym_valid(o_sv[0]),
      .sym_bit(o_sb[0]), .sym_soft(o_ss[0]), .low_conf(o_lc[0]),
      .saturated(o_sat[0]), .symbol_count(o_cnt[0])
   );

   bpsk_correlator_demod #(
      .DATA_WIDTH(16), .SAMPLES_PER_SYMBOL(SPS), .ACC_WIDTH(20),
      .SOFT_WIDTH(16), .SOFT_SHIFT(8), .DIFFERENTIAL(1'b1)
   ) u_b (
      .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid),
      .signal(signal), .ref_phase(o_ph[1]), .ref_amp(amp[1]),
      .resync(resync), .threshold(thr_b), .sym_valid(o_sv[1]),
      .sym_bit(o_sb[1]), .sym_soft(o_ss[1]), .low_conf(o_lc[1]),
      .saturated(o_sat[1]), .symbol_count(o_cnt[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model of one instance for the inputs present at the coming edge.
   task automatic model_update(input int k);
      longint hi, lo, prod, sum, mag;
      bit clip, dec;
      int idx;
      hi = (64'sd1 <<< (acc_w[k] - 1)) - 1;
      lo = -hi - 1;
      e_sv[k] = 1'b0;
      if (!reset_n) begin
         m_acc[k] = 0; m_phase[k] = 0; m_sat[k] = 0; m_prev[k] = 0;
         e_sb[k] = 0; e_ss[k] = 0; e_lc[k] = 0; e_sat[k] = 0; e_cnt[k] = 0;
      end else if (sample_valid) begin
         idx  = resync ? 0 : m_phase[k];
         prod = longint'(signal) * longint'(amps[idx]);
         sum  = (resync ? 64'sd0 : m_acc[k]) + prod;
         clip = (sum > hi) || (sum < lo);
         if (sum > hi) sum = hi;
         if (sum < lo) sum = lo;
         if (resync) begin
            m_acc[k] = sum; m_phase[k] = 1; m_sat[k] = 0;
         end else if (m_phase[k] == SPS - 1) begin
            dec       = (sum < 0);
            e_sb[k]   = diff[k] ? (dec ^ m_prev[k]) : dec;
            m_prev[k] = dec;
            e_ss[k]   = sum >>> 8;
            if (e_ss[k] > 32767)  e_ss[k] = 32767;
            if (e_ss[k] < -32768) e_ss[k] = -32768;
            mag       = (sum == lo) ? hi : ((sum < 0) ? -sum : sum);
            e_lc[k]   = (mag < 1000);
            e_sat[k]  = m_sat[k] | clip;
            e_sv[k]   = 1'b1;
            e_cnt[k]  = (e_cnt[k] + 1) & 16'hFFFF;
            m_acc[k] = 0; m_phase[k] = 0; m_sat[k] = 0;
         end else begin
            m_acc[k] = sum; m_phase[k]++; m_sat[k] |= clip;
         end
      end else if (resync) begin
         m_acc[k] = 0; m_phase[k] = 0; m_sat[k] = 0;
      end
   endtask

   // Compare process: every output of both instances on every falling edge.
   always @(negedge clock) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d sym_valid", k),    o_sv[k],  e_sv[k]);
            check($sformatf("u%0d sym_bit", k),      o_sb[k],  e_sb[k]);
            check($sformatf("u%0d sym_soft", k),     o_ss[k],  e_ss[k]);
            check($sformatf("u%0d low_conf", k),     o_lc[k],  e_lc[k]);
            check($sformatf("u%0d saturated", k),    o_sat[k], e_sat[k]);
            check($sformatf("u%0d symbol_count", k), o_cnt[k], e_cnt[k]);
            check($sformatf("u%0d ref_phase", k),    o_ph[k],
                  resync ? 0 : m_phase[k]);
         end
      end
   end

   // Drive one cycle; inputs change 1 time unit after the rising edge.
   task automatic step(input bit v, input logic signed [15:0] s,
                       input bit r, input bit rn = 1'b1);
      sample_valid = v;
      signal       = s;
      resync       = r;
      reset_n      = rn;
      @(posedge clock);
      model_update(0);
      model_update(1);
      #1;
   endtask

   task automatic sym(input logic signed [15:0] s0, input logic signed [15:0] s1,
                      input logic signed [15:0] s2, input logic signed [15:0] s3);
      step(1, s0, 0); step(1, s1, 0); step(1, s2, 0); step(1, s3, 0);
   endtask

   initial begin
      sample_valid = 0; signal = '0; resync = 0; reset_n = 0;
      thr_a = 47'd1000; thr_b = 19'd1000;

      step(0, 0, 0, 0);
      chk_en = 1;
      step(0, 0, 0, 0);
      check("reset sym_valid", o_sv[0], 0);
      check("reset symbol_count", o_cnt[0], 0);
      step(0, 0, 0);

      // Basic symbol: final = 100*1000 + (-100)*(-1000) = 200000.
      sym(0, 100, 0, -100);
      check("s1 sym_valid", o_sv[0], 1);
      check("s1 sym_bit", o_sb[0], 0);
      check("s1 sym_soft", o_ss[0], 781);
      check("s1 low_conf", o_lc[0], 0);
      check("s1 symbol_count", o_cnt[0], 1);
      step(0, 0, 0);
      check("s1 pulse width", o_sv[0], 0);

      sym(0, -100, 0, 100);
      check("s2 sym_bit", o_sb[0], 1);
      check("s2 sym_soft", o_ss[0], -782);

      sym(0, 0, 0, 0);
      check("s3 sym_bit", o_sb[0], 0);
      check("s3 sym_soft", o_ss[0], 0);
      check("s3 low_conf", o_lc[0], 1);

      // Valid gaps of 3 cycles between samples.
      step(1, 0, 0);    repeat (3) step(0, 0, 0);
      step(1, 100, 0);  repeat (3) step(0, 0, 0);
      step(1, 0, 0);    repeat (3) step(0, 0, 0);
      check("gap early sym_valid", o_sv[0], 0);
      step(1, -100, 0);
      check("gap sym_valid", o_sv[0], 1);
      check("gap sym_soft", o_ss[0], 781);
      check("gap symbol_count", o_cnt[0], 4);
      repeat (3) step(0, 0, 0);

      // Differential decoding: decisions 0,1,1,0 -> bits 0,1,0,1.
      step(0, 0, 0, 0);
      sym(0, 100, 0, -100);  check("diff bit0", o_sb[1], 0);
      sym(0, -100, 0, 100);  check("diff bit1", o_sb[1], 1);
      sym(0, -100, 0, 100);  check("diff bit2", o_sb[1], 0);
      sym(0, 100, 0, -100);  check("diff bit3", o_sb[1], 1);

      // Resync: idle resync clears a partial symbol, then a resync sample
      // restarts mid-symbol; only post-resync samples count.
      step(1, 7, 0); step(1, -300, 0);
      step(0, 0, 1);
      step(1, 9, 0); step(1, -300, 0);
      step(1, 0, 1);
      check("resync no emit", o_sv[0], 0);
      step(1, 100, 0); step(1, 0, 0); step(1, -100, 0);
      check("resync sym_valid", o_sv[0], 1);
      check("resync sym_soft", o_ss[0], 781);
      check("resync symbol_count", o_cnt[0], 5);

      // Resync on a final-phase sample wins over emission.
      step(1, 5, 0); step(1, -300, 0); step(1, 5, 0);
      step(1, 0, 1);
      check("resync final no emit", o_sv[0], 0);
      step(1, 100, 0); step(1, 0, 0); step(1, -100, 0);
      check("resync final symbol_count", o_cnt[0], 6);

      // Full-scale samples clip the 20-bit accumulator only.
      sym(0, 32767, 0, -32768);
      check("sat narrow saturated", o_sat[1], 1);
      check("sat narrow sym_soft", o_ss[1], 2047);
      check("sat wide saturated", o_sat[0], 0);
      check("sat wide sym_soft", o_ss[0], 32767);
      sym(0, 100, 0, -100);
      check("sat cleared", o_sat[1], 0);

      // Reset mid-symbol discards the partial symbol.
      step(1, 0, 0); step(1, -300, 0);
      step(1, 0, 0, 0);
      check("mid reset symbol_count", o_cnt[0], 0);
      check("mid reset sym_soft", o_ss[0], 0);
      check("mid reset ref_phase", o_ph[0], 0);
      step(1, 0, 0); step(1, 100, 0); step(1, 0, 0);
      check("mid reset no emit", o_sv[0], 0);
      step(1, -100, 0);
      check("mid reset sym_valid", o_sv[0], 1);
      check("mid reset new count", o_cnt[0], 1);
      check("mid reset new soft", o_ss[0], 781);
      step(0, 0, 0); step(0, 0, 0);

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
